// File: rtl/ddr2_cmd_sequencer.sv
// rtl/ddr2_cmd_sequencer.sv - single-request DDR2 command sequencer with per-bank timing tracking
module ddr2_cmd_sequencer #(
  parameter int T_RCD = 3,
  parameter int T_RP  = 3,
  parameter int T_RAS = 9,
  parameter int T_RC  = 12,
  parameter int T_RRD = 2,
  parameter int T_FAW = 10,
  parameter int T_WR  = 6,
  parameter int T_RTP = 2,
  parameter int T_WTR = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_bank,
  input  logic [12:0] req_row,
  input  logic [9:0]  req_col,
  output logic        ddr_cke,
  output logic        ddr_cs_n,
  output logic        ddr_ras_n,
  output logic        ddr_cas_n,
  output logic        ddr_we_n,
  output logic [2:0]  ddr_ba,
  output logic [12:0] ddr_addr,
  output logic        cmd_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;
  localparam logic [1:0] S_CAS  = 2'd3;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_DES = 4'b1111;

  localparam logic [4:0] RCD = 5'(T_RCD);
  localparam logic [4:0] RP  = 5'(T_RP);
  localparam logic [4:0] RAS = 5'(T_RAS);
  localparam logic [4:0] RC  = 5'(T_RC);
  localparam logic [4:0] RRD = 5'(T_RRD);
  localparam logic [4:0] FAW = 5'(T_FAW);
  localparam logic [4:0] WR  = 5'(T_WR);
  localparam logic [4:0] RTP = 5'(T_RTP);
  localparam logic [4:0] WTR = 5'(T_WTR);
  localparam logic [4:0] SAT = 5'd31;

  logic [1:0]  state;
  logic        q_write;
  logic [2:0]  q_bank;
  logic [12:0] q_row;
  logic [9:0]  q_col;

  logic [7:0]  bank_open;
  logic [12:0] bank_row    [8];
  logic [4:0]  bank_act_el [8];
  logic [4:0]  bank_pre_el [8];
  logic [4:0]  act_el;
  logic [4:0]  rd_el;
  logic [4:0]  wr_el;
  logic [4:0]  faw_el      [4];

  logic [2:0]  held_ba;
  logic [12:0] held_addr;
  logic [3:0]  cmd;

  logic accept, row_hit;
  logic pre_ok, act_ok, cas_ok;
  logic issue_pre, issue_act, issue_cas, issue_any;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == SAT) ? v : v + 5'd1;
  endfunction

  assign req_ready = ddr_cke && (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign row_hit   = bank_open[req_bank] && (bank_row[req_bank] == req_row);

  // faw_el[3] is the age of the fourth-most-recent ACT; a fifth ACT must fall outside its window
  assign pre_ok = (bank_act_el[q_bank] >= RAS) && (wr_el >= WR) && (rd_el >= RTP);
  assign act_ok = (bank_pre_el[q_bank] >= RP) && (bank_act_el[q_bank] >= RC) &&
                  (act_el >= RRD) && (faw_el[3] >= FAW);
  assign cas_ok = (bank_act_el[q_bank] >= RCD) && (q_write || (wr_el >= WTR));

  assign issue_pre = (state == S_PRE) && pre_ok;
  assign issue_act = (state == S_ACT) && act_ok;
  assign issue_cas = (state == S_CAS) && cas_ok;
  assign issue_any = issue_pre || issue_act || issue_cas;
  assign cmd_done  = issue_cas;

  always_comb begin
    cmd      = CMD_NOP;
    ddr_ba   = held_ba;
    ddr_addr = held_addr;
    if (!ddr_cke) begin
      cmd = CMD_DES;
    end else if (issue_pre) begin
      cmd      = CMD_PRE;
      ddr_ba   = q_bank;
      ddr_addr = '0;
    end else if (issue_act) begin
      cmd      = CMD_ACT;
      ddr_ba   = q_bank;
      ddr_addr = q_row;
    end else if (issue_cas) begin
      cmd      = q_write ? CMD_WR : CMD_RD;
      ddr_ba   = q_bank;
      ddr_addr = {3'b000, q_col};
    end
  end

  assign {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} = cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ddr_cke   <= 1'b0;
      q_write   <= 1'b0;
      q_bank    <= '0;
      q_row     <= '0;
      q_col     <= '0;
      bank_open <= '0;
      held_ba   <= '0;
      held_addr <= '0;
      for (int i = 0; i < 8; i++) begin
        bank_row[i] <= '0;
      end
    end else begin
      ddr_cke <= 1'b1;
      if (issue_any) begin
        held_ba   <= ddr_ba;
        held_addr <= ddr_addr;
      end
      case (state)
        S_IDLE: if (accept) begin
          q_write <= req_write;
          q_bank  <= req_bank;
          q_row   <= req_row;
          q_col   <= req_col;
          if (row_hit)                  state <= S_CAS;
          else if (bank_open[req_bank]) state <= S_PRE;
          else                          state <= S_ACT;
        end
        S_PRE: if (issue_pre) begin
          bank_open[q_bank] <= 1'b0;
          state             <= S_ACT;
        end
        S_ACT: if (issue_act) begin
          bank_open[q_bank] <= 1'b1;
          bank_row[q_bank]  <= q_row;
          state             <= S_CAS;
        end
        default: if (issue_cas) state <= S_IDLE;
      endcase
    end
  end

  // Counters reload to 1 so that in each later cycle they read the cycles elapsed since the command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_el <= SAT;
      rd_el  <= SAT;
      wr_el  <= SAT;
      for (int i = 0; i < 8; i++) begin
        bank_act_el[i] <= SAT;
        bank_pre_el[i] <= SAT;
      end
      for (int i = 0; i < 4; i++) begin
        faw_el[i] <= SAT;
      end
    end else begin
      act_el <= issue_act ? 5'd1 : sat_inc(act_el);
      rd_el  <= (issue_cas && !q_write) ? 5'd1 : sat_inc(rd_el);
      wr_el  <= (issue_cas && q_write) ? 5'd1 : sat_inc(wr_el);
      for (int i = 0; i < 8; i++) begin
        bank_act_el[i] <= (issue_act && (q_bank == 3'(i))) ? 5'd1 : sat_inc(bank_act_el[i]);
        bank_pre_el[i] <= (issue_pre && (q_bank == 3'(i))) ? 5'd1 : sat_inc(bank_pre_el[i]);
      end
      faw_el[0] <= issue_act ? 5'd1 : sat_inc(faw_el[0]);
      for (int i = 1; i < 4; i++) begin
        faw_el[i] <= issue_act ? sat_inc(faw_el[i-1]) : sat_inc(faw_el[i]);
      end
    end
  end

endmodule

// File: tb/tb_ddr2_cmd_sequencer.sv
// tb/tb_ddr2_cmd_sequencer.sv - directed and randomized checks against an absolute-time timing model
module tb_ddr2_cmd_sequencer;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam int NEVER = -1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [2:0] req_bank = '0;
  logic [12:0] req_row = '0;
  logic [9:0] req_col = '0;
  logic sel = 1'b0;

  logic a_ready, a_cke, a_cs, a_ras, a_cas, a_we, a_done;
  logic [2:0] a_ba;
  logic [12:0] a_addr;
  logic b_ready, b_cke, b_cs, b_ras, b_cas, b_we, b_done;
  logic [2:0] b_ba;
  logic [12:0] b_addr;

  logic o_ready, o_cke, o_done;
  logic [3:0] o_cmd;
  logic [2:0] o_ba;
  logic [12:0] o_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr2_cmd_sequencer u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(a_ready),
    .req_write(req_write), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .ddr_cke(a_cke), .ddr_cs_n(a_cs), .ddr_ras_n(a_ras), .ddr_cas_n(a_cas), .ddr_we_n(a_we),
    .ddr_ba(a_ba), .ddr_addr(a_addr), .cmd_done(a_done)
  );

  ddr2_cmd_sequencer #(.T_RCD(1), .T_FAW(20)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(b_ready),
    .req_write(req_write), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .ddr_cke(b_cke), .ddr_cs_n(b_cs), .ddr_ras_n(b_ras), .ddr_cas_n(b_cas), .ddr_we_n(b_we),
    .ddr_ba(b_ba), .ddr_addr(b_addr), .cmd_done(b_done)
  );

  always_comb begin
    o_ready = a_ready; o_cke = a_cke; o_done = a_done;
    o_cmd = {a_cs, a_ras, a_cas, a_we}; o_ba = a_ba; o_addr = a_addr;
    if (sel) begin
      o_ready = b_ready; o_cke = b_cke; o_done = b_done;
      o_cmd = {b_cs, b_ras, b_cas, b_we}; o_ba = b_ba; o_addr = b_addr;
    end
  end

  // Reference model: absolute cycle of each past command, earliest legal issue = max of constraints
  int p_rcd, p_rp, p_ras, p_rc, p_rrd, p_faw, p_wr, p_rtp, p_wtr;
  bit m_open [8];
  int m_row [8];
  int m_act [8];
  int m_pre [8];
  int m_last_rd, m_last_wr;
  int m_hist [4];
  logic [2:0] m_ba;
  logic [12:0] m_addr;

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void set_params(input bit fast);
    p_rcd = fast ? 1 : 3; p_rp = 3; p_ras = 9; p_rc = 12; p_rrd = 2;
    p_faw = fast ? 20 : 10; p_wr = 6; p_rtp = 2; p_wtr = 4;
  endfunction

  function automatic void reset_model();
    for (int i = 0; i < 8; i++) begin
      m_open[i] = 1'b0; m_row[i] = 0; m_act[i] = NEVER; m_pre[i] = NEVER;
    end
    for (int i = 0; i < 4; i++) m_hist[i] = NEVER;
    m_last_rd = NEVER; m_last_wr = NEVER; m_ba = '0; m_addr = '0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic do_req(input bit w, input int b, input int r, input int c, input int gap,
                        output int n, output int t_pre, output int t_act, output int t_cas,
                        output logic [12:0] cas_addr);
    int e_pre, e_act, e_cas, t;
    logic [3:0] exp_cmd;
    logic exp_done;
    logic [12:0] rv, cv;
    rv = r[12:0];
    cv = {3'b000, c[9:0]};
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      checks++;
      if (o_cmd !== NOP || o_done !== 1'b0 || o_ready !== 1'b1 || o_ba !== m_ba || o_addr !== m_addr) begin
        failures++;
        $display("FAIL idle_gap cyc=%0d got cmd=%b done=%b ready=%b ba=%0d addr=%h want cmd=%b done=0 ready=1 ba=%0d addr=%h",
                 cyc, o_cmd, o_done, o_ready, o_ba, o_addr, NOP, m_ba, m_addr);
      end
    end
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready cyc=%0d got ready=%b want 1", cyc, o_ready);
    end
    req_valid = 1'b1; req_write = w; req_bank = b[2:0]; req_row = rv; req_col = c[9:0];
    n = cyc;
    t = n + 1; e_pre = -1; e_act = -1;
    if (!(m_open[b] && m_row[b] == r)) begin
      if (m_open[b]) begin
        e_pre = mx(mx(t, m_act[b] + p_ras), mx(m_last_wr + p_wr, m_last_rd + p_rtp));
        m_pre[b] = e_pre; m_open[b] = 1'b0; t = e_pre + 1;
      end
      e_act = mx(mx(t, m_pre[b] + p_rp), mx(m_act[b] + p_rc, mx(m_hist[0] + p_rrd, m_hist[3] + p_faw)));
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = e_act; m_act[b] = e_act; m_open[b] = 1'b1; m_row[b] = r; t = e_act + 1;
    end
    e_cas = mx(t, m_act[b] + p_rcd);
    if (!w) e_cas = mx(e_cas, m_last_wr + p_wtr);
    if (w) m_last_wr = e_cas; else m_last_rd = e_cas;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_bank = 3'($urandom); req_row = 13'($urandom); req_col = 10'($urandom);
    t_pre = -1; t_act = -1; t_cas = -1; cas_addr = '0;
    for (int k = n + 1; k <= e_cas; k++) begin
      @(negedge clk);
      exp_cmd = NOP; exp_done = 1'b0;
      if (k == e_pre) begin
        exp_cmd = PRE; m_ba = b[2:0]; m_addr = '0;
      end else if (k == e_act) begin
        exp_cmd = ACT; m_ba = b[2:0]; m_addr = rv;
      end else if (k == e_cas) begin
        exp_cmd = w ? WR : RD; m_ba = b[2:0]; m_addr = cv; exp_done = 1'b1;
      end
      if (o_cmd === PRE && t_pre < 0) t_pre = cyc;
      if (o_cmd === ACT && t_act < 0) t_act = cyc;
      if ((o_cmd === RD || o_cmd === WR) && t_cas < 0) begin
        t_cas = cyc; cas_addr = o_addr;
      end
      checks++;
      if (o_cmd !== exp_cmd || o_done !== exp_done || o_ready !== 1'b0 || o_cke !== 1'b1 ||
          o_ba !== m_ba || o_addr !== m_addr) begin
        failures++;
        $display("FAIL req_cycle cyc=%0d acc=%0d got cmd=%b done=%b ready=%b ba=%0d addr=%h want cmd=%b done=%b ready=0 ba=%0d addr=%h",
                 cyc, n, o_cmd, o_done, o_ready, o_ba, o_addr, exp_cmd, exp_done, m_ba, m_addr);
      end
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; set_params(1'b0); reset_model();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_cke !== 1'b0 || o_cmd !== 4'b1111 || o_ba !== 3'd0 || o_addr !== 13'd0 ||
        o_ready !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got cke=%b cmd=%b ba=%0d addr=%h ready=%b done=%b want 0 1111 0 0 0 0",
               o_cke, o_cmd, o_ba, o_addr, o_ready, o_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_cke !== 1'b1 || o_cmd !== NOP || o_ready !== 1'b1 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got cke=%b cmd=%b ready=%b done=%b want 1 0111 1 0",
               o_cke, o_cmd, o_ready, o_done);
    end
  endtask

  task automatic test_row_hit();
    int n0, n1, tp, ta, tc;
    logic [12:0] ca;
    do_reset();
    do_req(1'b0, 0, 5, 0, 0, n0, tp, ta, tc, ca);
    checks++;
    if (ta - n0 !== 1 || tc - n0 !== 4 || tp !== -1) begin
      failures++;
      $display("FAIL first_read got act=+%0d rd=+%0d pre=%0d want act=+1 rd=+4 pre=-1", ta - n0, tc - n0, tp);
    end
    do_req(1'b0, 0, 5, 'h3A, 0, n1, tp, ta, tc, ca);
    checks++;
    if (n1 - n0 !== 5 || tc - n0 !== 6 || ta !== -1 || tp !== -1 || ca !== 13'h03A) begin
      failures++;
      $display("FAIL row_hit got acc=+%0d rd=+%0d act=%0d pre=%0d addr=%h want acc=+5 rd=+6 act=-1 pre=-1 addr=03a",
               n1 - n0, tc - n0, ta, tp, ca);
    end
  endtask

  task automatic test_row_miss();
    int n0, n1, tp, ta, tc;
    logic [12:0] ca;
    do_reset();
    do_req(1'b0, 0, 5, 0, 0, n0, tp, ta, tc, ca);
    do_req(1'b0, 0, 7, 1, 0, n1, tp, ta, tc, ca);
    checks++;
    if (n1 - n0 !== 5 || tp - n0 !== 10 || ta - n0 !== 13 || tc - n0 !== 16) begin
      failures++;
      $display("FAIL row_miss got acc=+%0d pre=+%0d act=+%0d rd=+%0d want 5 10 13 16",
               n1 - n0, tp - n0, ta - n0, tc - n0);
    end
  endtask

  task automatic test_faw();
    int n0, n, tp, ta, tc;
    int want_act [5];
    logic [12:0] ca;
    want_act = '{1, 4, 7, 10, 21};
    sel = 1'b1; set_params(1'b1);
    do_reset();
    for (int b = 0; b < 5; b++) begin
      do_req(1'b0, b, 0, 0, 0, n, tp, ta, tc, ca);
      if (b == 0) n0 = n;
      checks++;
      if (ta - n0 !== want_act[b]) begin
        failures++;
        $display("FAIL faw_act bank=%0d got act=+%0d want +%0d", b, ta - n0, want_act[b]);
      end
    end
    checks++;
    if (n - n0 !== 12) begin
      failures++;
      $display("FAIL faw_accept got +%0d want +12", n - n0);
    end
    for (int i = 0; i < 30; i++) begin
      do_req(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1023)), int'($urandom_range(0, 2)), n, tp, ta, tc, ca);
    end
    sel = 1'b0; set_params(1'b0);
  endtask

  task automatic test_write_read();
    int n, tp, ta, tc, t_wr;
    logic [12:0] ca;
    do_reset();
    do_req(1'b0, 1, 3, 0, 0, n, tp, ta, tc, ca);
    do_req(1'b1, 1, 3, 5, 0, n, tp, ta, t_wr, ca);
    do_req(1'b0, 1, 3, 6, 0, n, tp, ta, tc, ca);
    checks++;
    if (tc - t_wr !== 4) begin
      failures++;
      $display("FAIL wtr got rd=wr+%0d want wr+4", tc - t_wr);
    end
    do_req(1'b0, 1, 4, 0, 0, n, tp, ta, tc, ca);
    checks++;
    if (tp - t_wr !== 6) begin
      failures++;
      $display("FAIL write_recovery got pre=wr+%0d want wr+6", tp - t_wr);
    end
  endtask

  task automatic test_reset_mid();
    int n, tp, ta, tc;
    logic [12:0] ca;
    do_reset();
    do_req(1'b0, 0, 5, 0, 0, n, tp, ta, tc, ca);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_bank = 3'd0; req_row = 13'd7; req_col = 10'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (o_cmd !== NOP || o_done !== 1'b0 || o_ready !== 1'b0) begin
        failures++;
        $display("FAIL pre_wait got cmd=%b done=%b ready=%b want 0111 0 0", o_cmd, o_done, o_ready);
      end
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o_cke !== 1'b0 || o_cmd !== 4'b1111 || o_done !== 1'b0 || o_ready !== 1'b0 ||
          o_ba !== 3'd0 || o_addr !== 13'd0) begin
        failures++;
        $display("FAIL mid_reset got cke=%b cmd=%b done=%b ready=%b ba=%0d addr=%h want 0 1111 0 0 0 0",
                 o_cke, o_cmd, o_done, o_ready, o_ba, o_addr);
      end
      if (i < 2) @(negedge clk);
    end
    rst_n = 1'b1;
    reset_model();
    do_req(1'b0, 0, 9, 0, 0, n, tp, ta, tc, ca);
    checks++;
    if (tp !== -1 || ta - n !== 1) begin
      failures++;
      $display("FAIL after_reset got pre=%0d act=+%0d want pre=-1 act=+1", tp, ta - n);
    end
  endtask

  task automatic test_random();
    int n, tp, ta, tc;
    logic [12:0] ca;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      do_req(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)), n, tp, ta, tc, ca);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_row_hit();
    test_row_miss();
    test_faw();
    test_write_read();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr2_cmd_sequencer.md
DDR2_CMD_SEQUENCER -- requirements
Module: ddr2_cmd_sequencer

Interface
REQ-001 Parameters, in clk cycles (name, default, meaning); each SHALL lie in 1..31:
- T_RCD 3: ACT to RD/WR, same bank
- T_RP 3: PRE to ACT, same bank
- T_RAS 9: ACT to PRE, same bank
- T_RC 12: ACT to ACT, same bank
- T_RRD 2: ACT to ACT, any bank
- T_FAW 10: window for four ACTs
- T_WR 6: WR to PRE
- T_RTP 2: RD to PRE
- T_WTR 4: WR to RD
REQ-002 Ports (name, direction, width, meaning):
- clk in 1: clock
- rst_n in 1: reset, asynchronous, active-low
- req_valid in 1: request present
- req_ready out 1: request accepted on valid&&ready
- req_write in 1: 1 = write, 0 = read
- req_bank in 3: target bank
- req_row in 13: target row
- req_col in 10: target column
- ddr_cke out 1: clock enable
- ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n out 1 each: command pins
- ddr_ba out 3: bank address
- ddr_addr out 13: row/column address
- cmd_done out 1: one-cycle pulse in the cycle the request's RD/WR is driven

Function
REQ-003 Encodings {cs_n,ras_n,cas_n,we_n}: NOP=0111, ACT=0011, PRE=0010, RD=0101, WR=0100; at most one command per cycle, NOP otherwise.
REQ-004 ACT drives ba=bank, addr=row; PRE drives ba=bank, addr=0 (addr[10]=0, single bank); RD/WR drive ba=bank, addr[9:0]=col, addr[12:10]=0 (no auto-precharge).
REQ-005 On NOP cycles ba and addr SHALL hold their last driven values.
REQ-006 Per bank the block SHALL track open flag, open row, elapsed-since-ACT and elapsed-since-PRE; globally elapsed-since-ACT, since-RD, since-WR, and elapsed of the last four ACTs.
REQ-007 Elapsed counters are 5 bits; they SHALL load 0 in the cycle the command is driven, increment each later cycle, and saturate at 31.
REQ-008 A command is eligible in a cycle only if every governing elapsed value is >= its parameter:
- PRE: bank ACT >= T_RAS, WR >= T_WR, RD >= T_RTP
- ACT: bank PRE >= T_RP, bank ACT >= T_RC, global ACT >= T_RRD, fourth-most-recent ACT >= T_FAW
- RD: bank ACT >= T_RCD, WR >= T_WTR
- WR: bank ACT >= T_RCD
REQ-009 FSM states IDLE, PRE, ACT, CAS; req_ready = 1 only in IDLE.
REQ-010 On accept, request fields SHALL be latched and next state chosen as follows:
- bank open, same row: CAS
- bank open, other row: PRE
- bank closed: ACT
REQ-011 PRE, ACT and CAS SHALL drive NOP until their command is eligible, then issue it.
- PRE: clears the bank open flag, goes to ACT.
- ACT: sets the open flag, records the row, goes to CAS.
- CAS: issues RD or WR per req_write, pulses cmd_done, returns to IDLE.
REQ-012 A request is held to completion once accepted; req_valid/fields changes after accept SHALL be ignored.
REQ-013 Minimum latency from accept cycle N:
- row hit: RD/WR at N+1
- closed bank: ACT at N+1
- row miss: PRE at N+1

Reset
REQ-014 While rst_n=0:
- ddr_cke=0, command pins 1111 (deselect), ba=0, addr=0
- req_ready=0, cmd_done=0
- state IDLE, all banks closed, all elapsed counters saturated at 31
REQ-015 From the first clk edge after rst_n deasserts: ddr_cke=1, commands are NOP or valid commands, req_ready=1.
REQ-016 Reset asserted mid-request SHALL abandon the request immediately with no completion pulse.

Verification (defaults unless stated; accept at cycle 0)
REQ-017 Read, bank 0, row 5, after reset -> ACT(ba0, addr5) cycle 1; RD cycle 4 with cmd_done=1; req_ready high again cycle 5.
REQ-018 Then read bank 0, row 5, col 0x3A accepted cycle 5 -> RD cycle 6, addr=0x03A, no ACT/PRE.
REQ-019 Read bank 0 row 5 (ACT at 1) then read bank 0 row 7 accepted cycle 5 -> PRE cycle 10; ACT addr7 cycle 13; RD cycle 16.
REQ-020 T_RCD=1, T_FAW=20, back-to-back reads to closed banks 0..4 -> ACTs at cycles 1, 4, 7, 10; bank 4 accepted cycle 12; ACT held to cycle 21.
REQ-021 Write to an open row at cycle t, then read to the same row -> RD not before t+4; PRE to that bank not before t+6.
REQ-022 rst_n low for two cycles while in PRE waiting on T_RAS -> pins 1111, cke=0, no cmd_done; after release, a request to the previously open bank issues ACT with no PRE.
